// File: rtl/uart_rx_ctrl.sv
// UART receive controller: enable sequencing with graceful stop, receive FIFO
// with registered pop port, sticky status flags and a level interrupt.
module uart_rx_ctrl #(
  parameter int PAYLOAD_BITS = 8,
  parameter int DEPTH        = 16,
  parameter int TO_BITS      = 16
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      cfg_rx_en,
  input  logic [$clog2(DEPTH):0]    cfg_thresh,
  input  logic [TO_BITS-1:0]        cfg_timeout,
  input  logic                      fifo_flush,
  input  logic [2:0]                clr_flags,
  output logic                      uart_rx_en,
  input  logic                      rx_valid,
  input  logic                      rx_break,
  input  logic                      rx_busy,
  input  logic [PAYLOAD_BITS-1:0]   rx_data,
  input  logic                      rd_en,
  output logic                      rd_valid,
  output logic [PAYLOAD_BITS-1:0]   rd_data,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic                      fifo_empty,
  output logic                      fifo_full,
  output logic [2:0]                flags,
  output logic                      irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {OFF, ON, DRAIN} state_t;

  state_t                  state_q;
  logic                    uart_rx_en_q;
  logic [PAYLOAD_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [PAYLOAD_BITS-1:0] rd_data_q, rd_data_d;
  logic [2:0]              flags_q, flags_d;
  logic                    irq_q, irq_d;
  logic [TO_BITS-1:0]      to_q, to_d;

  logic empty, full, push_req, pop_acc, push_acc, do_push, do_pop;
  logic overrun, brk, to_hit;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign push_req = rx_valid & ~rx_break;
  assign pop_acc  = rd_en & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the word.
  assign push_acc = push_req & (~full | pop_acc);
  assign do_pop   = pop_acc & ~fifo_flush;
  assign do_push  = push_acc & ~fifo_flush;
  assign overrun  = push_req & full & ~pop_acc;
  assign brk      = rx_valid & rx_break;
  assign to_hit   = (cfg_timeout != '0) && (to_q == cfg_timeout);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= OFF;
      uart_rx_en_q <= 1'b0;
    end else begin
      case (state_q)
        OFF: if (cfg_rx_en) begin
          state_q      <= ON;
          uart_rx_en_q <= 1'b1;
        end
        ON: if (!cfg_rx_en) begin
          state_q      <= rx_busy ? DRAIN : OFF;
          uart_rx_en_q <= rx_busy;
        end
        DRAIN: if (cfg_rx_en) begin
          state_q      <= ON;
          uart_rx_en_q <= 1'b1;
        end else if (rx_valid || !rx_busy) begin
          state_q      <= OFF;
          uart_rx_en_q <= 1'b0;
        end
        default: begin
          state_q      <= OFF;
          uart_rx_en_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_valid_d = do_pop;
    rd_data_d  = rd_data_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      rd_data_d = mem_q[rd_ptr_q];
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (fifo_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    // Idle timer only runs while data sits unread in the FIFO.
    to_d = to_q;
    if (do_push || do_pop || fifo_flush || empty || cfg_timeout == '0)
      to_d = '0;
    else if (to_q != '1)
      to_d = to_q + TO_BITS'(1);

    flags_d = (flags_q & ~clr_flags) | {to_hit, brk, overrun};
    irq_d   = ((cfg_thresh != '0) && (count_q >= cfg_thresh)) | (|flags_q);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      flags_q    <= '0;
      irq_q      <= 1'b0;
      to_q       <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      flags_q    <= flags_d;
      irq_q      <= irq_d;
      to_q       <= to_d;
    end
  end

  assign uart_rx_en = uart_rx_en_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign fifo_count = count_q;
  assign fifo_empty = empty;
  assign fifo_full  = full;
  assign flags      = flags_q;
  assign irq        = irq_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a queue scoreboard of expected FIFO words.
module tb_uart_rx_ctrl;
  logic       clk = 1'b0;
  logic       resetn;
  logic       cfg_rx_en;
  logic [4:0] cfg_thresh;
  logic [15:0] cfg_timeout;
  logic       fifo_flush;
  logic [2:0] clr_flags;
  logic       uart_rx_en;
  logic       rx_valid, rx_break, rx_busy;
  logic [7:0] rx_data;
  logic       rd_en;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [4:0] fifo_count;
  logic       fifo_empty, fifo_full;
  logic [2:0] flags;
  logic       irq;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  uart_rx_ctrl dut (
    .clk(clk), .resetn(resetn), .cfg_rx_en(cfg_rx_en), .cfg_thresh(cfg_thresh),
    .cfg_timeout(cfg_timeout), .fifo_flush(fifo_flush), .clr_flags(clr_flags),
    .uart_rx_en(uart_rx_en), .rx_valid(rx_valid), .rx_break(rx_break),
    .rx_busy(rx_busy), .rx_data(rx_data), .rd_en(rd_en), .rd_valid(rd_valid),
    .rd_data(rd_data), .fifo_count(fifo_count), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .flags(flags), .irq(irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_w(input logic [7:0] d);
    rx_valid = 1'b1;
    rx_data  = d;
    if (sb.size() < 16) sb.push_back(d);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pop_chk(input string tag);
    logic [7:0] exp;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
    chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    chk({tag, "_data"}, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    resetn = 1'b0; cfg_rx_en = 1'b0; cfg_thresh = '0; cfg_timeout = '0;
    fifo_flush = 1'b0; clr_flags = '0; rx_valid = 1'b0; rx_break = 1'b0;
    rx_busy = 1'b0; rx_data = '0; rd_en = 1'b0;
    tick(); tick();
    chk("rst_en", 32'(uart_rx_en), 32'd0);
    chk("rst_rdv", 32'(rd_valid), 32'd0);
    chk("rst_rdd", 32'(rd_data), 32'd0);
    chk("rst_cnt", 32'(fifo_count), 32'd0);
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    resetn = 1'b1;

    // 1: basic ordering
    cfg_rx_en = 1'b1;
    tick();
    chk("t1_en", 32'(uart_rx_en), 32'd1);
    push_w(8'h41); push_w(8'h42); push_w(8'h43);
    chk("t1_cnt3", 32'(fifo_count), 32'd3);
    for (int i = 0; i < 3; i++) pop_chk("t1_pop");
    chk("t1_cnt0", 32'(fifo_count), 32'd0);
    tick();
    chk("t1_rdv_drop", 32'(rd_valid), 32'd0);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("t1_empty_pop_v", 32'(rd_valid), 32'd0);
    chk("t1_empty_pop_d", 32'(rd_data), 32'h43);

    // 2: overflow
    for (int i = 0; i < 16; i++) push_w(8'(8'h10 + i));
    chk("t2_full", 32'(fifo_full), 32'd1);
    chk("t2_no_ovr", 32'(flags), 32'd0);
    push_w(8'hEE);
    chk("t2_ovr", 32'(flags), 32'd1);
    chk("t2_cnt", 32'(fifo_count), 32'd16);
    tick();
    chk("t2_irq", 32'(irq), 32'd1);
    for (int i = 0; i < 16; i++) pop_chk("t2_pop");
    chk("t2_empty", 32'(fifo_empty), 32'd1);
    clr_flags = 3'b111; tick(); clr_flags = '0;
    chk("t2_clr", 32'(flags), 32'd0);
    tick();
    chk("t2_irq_off", 32'(irq), 32'd0);

    // 3: simultaneous push+pop when full
    for (int i = 0; i < 16; i++) push_w(8'(8'h80 + i));
    chk("t3_full", 32'(fifo_full), 32'd1);
    rx_valid = 1'b1; rx_data = 8'hAA; rd_en = 1'b1;
    tick();
    rx_valid = 1'b0; rd_en = 1'b0;
    chk("t3_pp_v", 32'(rd_valid), 32'd1);
    chk("t3_pp_d", 32'(rd_data), 32'(sb.pop_front()));
    sb.push_back(8'hAA);
    chk("t3_cnt", 32'(fifo_count), 32'd16);
    chk("t3_no_ovr", 32'(flags), 32'd0);
    for (int i = 0; i < 16; i++) pop_chk("t3_pop");
    chk("t3_empty", 32'(fifo_empty), 32'd1);

    // 4: graceful disable during a frame
    rx_busy = 1'b1; cfg_rx_en = 1'b0;
    tick();
    chk("t4_drain1", 32'(uart_rx_en), 32'd1);
    tick();
    chk("t4_drain2", 32'(uart_rx_en), 32'd1);
    push_w(8'h55);
    rx_busy = 1'b0;
    chk("t4_off", 32'(uart_rx_en), 32'd0);
    chk("t4_cnt", 32'(fifo_count), 32'd1);
    pop_chk("t4_pop");
    cfg_rx_en = 1'b1; tick();
    chk("t4_on", 32'(uart_rx_en), 32'd1);
    cfg_rx_en = 1'b0; tick();
    chk("t4_idle_off", 32'(uart_rx_en), 32'd0);

    // 5: receive timeout
    cfg_timeout = 16'd100;
    push_w(8'h66);
    repeat (100) tick();
    chk("t5_not_yet", 32'(flags[2]), 32'd0);
    tick();
    chk("t5_timeout", 32'(flags[2]), 32'd1);
    clr_flags = 3'b100; tick(); clr_flags = '0;
    chk("t5_clr", 32'(flags), 32'd0);
    cfg_timeout = '0;
    pop_chk("t5_pop");
    tick();

    // 6: break and threshold irq
    rx_valid = 1'b1; rx_break = 1'b1; rx_data = 8'hFF;
    tick();
    rx_valid = 1'b0; rx_break = 1'b0;
    chk("t6_brk", 32'(flags), 32'd2);
    chk("t6_brk_cnt", 32'(fifo_count), 32'd0);
    clr_flags = 3'b010; tick(); clr_flags = '0;
    tick();
    cfg_thresh = 5'd2;
    push_w(8'h01);
    push_w(8'h02);
    chk("t6_irq_lag", 32'(irq), 32'd0);
    tick();
    chk("t6_irq", 32'(irq), 32'd1);

    // flush empties the FIFO, flags untouched
    fifo_flush = 1'b1; tick(); fifo_flush = 1'b0;
    sb.delete();
    chk("fl_cnt", 32'(fifo_count), 32'd0);
    chk("fl_empty", 32'(fifo_empty), 32'd1);
    cfg_thresh = '0;

    // reset in the middle of a pop
    push_w(8'h77);
    push_w(8'h78);
    rd_en = 1'b1; resetn = 1'b0;
    tick();
    rd_en = 1'b0; resetn = 1'b1;
    sb.delete();
    chk("mr_cnt", 32'(fifo_count), 32'd0);
    chk("mr_rdv", 32'(rd_valid), 32'd0);
    chk("mr_rdd", 32'(rd_data), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
